// File: rtl/otter_perf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otter_perf_pkg
//  Description : Shared register map, bit positions and counting-mode
//                encoding for the OTTER performance-counter bank.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package otter_perf_pkg;

    // Byte offsets inside one 16-byte channel block
    localparam logic [3:0] REG_LO   = 4'h0;
    localparam logic [3:0] REG_HI   = 4'h4;
    localparam logic [3:0] REG_CTRL = 4'h8;

    // Offset of the GLOBAL register from the bank base
    localparam logic [8:0] GLOBAL_OFF = 9'h100;

    // CTRL bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_CLR  = 2;
    localparam int CTRL_OVF  = 3;

    // GLOBAL bit positions
    localparam int GLB_FREEZE  = 0;
    localparam int GLB_CLR_ALL = 1;

    typedef enum logic {
        CNT_CYCLES = 1'b0,
        CNT_EVENTS = 1'b1
    } cnt_mode_e;

endpackage : otter_perf_pkg
`default_nettype wire

// File: rtl/otter_perf_counters_ch.sv
`default_nettype none
// ============================================================================
//  Module      : perf_counter_ch
//  Description : One performance-counter channel: CNT_W-bit counter, CTRL
//                (EN/MODE), sticky OVF, event edge detector and the HI
//                snapshot register loaded when LO is read.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                evt               - event source for MODE = events
//                freeze, clr_all   - bank-wide hold / clear
//                ctrl_wr           - CTRL write strobe, ctrl_wdata = bits[2:0]
//                snap              - LO read strobe (loads HI snapshot)
//                lo, hi, ctrl      - 32-bit read views of this channel
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_counter_ch
    import otter_perf_pkg::*;
#(
    parameter int CNT_W  = 64,
    parameter bit EN_RST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        evt,
    input  logic        freeze,
    input  logic        clr_all,
    input  logic        ctrl_wr,
    input  logic [2:0]  ctrl_wdata,
    input  logic        snap,
    output logic [31:0] lo,
    output logic [31:0] hi,
    output logic [31:0] ctrl
);

    logic [CNT_W-1:0]  count;
    logic [CNT_W-33:0] shadow;
    cnt_mode_e         mode;
    logic              en;
    logic              ovf;
    logic              evt_prev;

    logic              inc;
    logic              clr;
    logic              wrap;

    // Event mode counts only the low-to-high transition, so a held-high
    // source contributes a single count.
    assign inc  = en && !freeze &&
                  ((mode == CNT_CYCLES) || (evt && !evt_prev));
    assign clr  = clr_all || (ctrl_wr && ctrl_wdata[CTRL_CLR]);
    assign wrap = inc && (&count);

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            shadow   <= '0;
            mode     <= CNT_CYCLES;
            en       <= EN_RST;
            ovf      <= 1'b0;
            evt_prev <= 1'b0;
        end else begin
            // The edge detector tracks the source unconditionally so that
            // enabling a channel never sees a stale "previous" level.
            evt_prev <= evt;

            if (ctrl_wr) begin
                en   <= ctrl_wdata[CTRL_EN];
                mode <= cnt_mode_e'(ctrl_wdata[CTRL_MODE]);
            end

            // Captures the pre-edge upper half, i.e. the half that belongs
            // with the LO value returned on the same bus cycle.
            if (snap) begin
                shadow <= count[CNT_W-1:32];
            end

            // Clear beats a simultaneous increment or wrap.
            if (clr) begin
                count <= '0;
                ovf   <= 1'b0;
            end else if (inc) begin
                count <= count + CNT_W'(1);
                if (wrap) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign lo = count[31:0];

    // Bits of HI above the implemented counter width read as zero.
    generate
        if (CNT_W == 64) begin : g_hi_full
            assign hi = shadow;
        end else begin : g_hi_pad
            assign hi = {{(64 - CNT_W){1'b0}}, shadow};
        end
    endgenerate

    always_comb begin
        ctrl            = '0;
        ctrl[CTRL_EN]   = en;
        ctrl[CTRL_MODE] = (mode == CNT_EVENTS);
        ctrl[CTRL_OVF]  = ovf;
    end

endmodule : perf_counter_ch
`default_nettype wire

// File: rtl/otter_perf_counters.sv
`default_nettype none
// ============================================================================
//  Module      : otter_perf_counters
//  Description : Memory-mapped bank of NUM_CH performance counters on the
//                OTTER IOBUS. Channel c lives at BASE_AD + 16*c (LO, HI,
//                CTRL); GLOBAL (FREEZE, CLR_ALL) at BASE_AD + 0x100.
//                Channel 0 comes out of reset as a free-running cycle
//                counter.
//  Ports       : CLK, RESET  - MCU clock, synchronous active-high reset
//                EVENTS      - per-channel event sources
//                IOBUS_ADDR  - bus address
//                IOBUS_OUT   - bus write data
//                IOBUS_WR    - write strobe
//                IOBUS_RD    - read strobe (qualifies the HI snapshot)
//                RD_DATA     - combinational read data, 0 when unmapped
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_perf_counters
    import otter_perf_pkg::*;
#(
    parameter int          NUM_CH  = 4,
    parameter int          CNT_W   = 64,
    parameter logic [31:0] BASE_AD = 32'h1140_0000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] EVENTS,
    input  logic [31:0]       IOBUS_ADDR,
    input  logic [31:0]       IOBUS_OUT,
    input  logic              IOBUS_WR,
    input  logic              IOBUS_RD,
    output logic [31:0]       RD_DATA
);

    logic        in_region;
    logic [8:0]  offset;
    logic        global_hit;
    logic        ch_space;
    logic [3:0]  ch_idx;
    logic [3:0]  reg_off;
    logic        global_wr;
    logic        freeze;
    logic        clr_all;

    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] ctrl_wr;
    logic [NUM_CH-1:0] snap;
    logic [31:0]       lo_rd   [NUM_CH];
    logic [31:0]       hi_rd   [NUM_CH];
    logic [31:0]       ctrl_rd [NUM_CH];

    // ------------------------------------------------------------------
    // Address decode: the bank occupies a 512-byte window; the lower half
    // holds up to 16 channel blocks, GLOBAL sits at 0x100.
    // ------------------------------------------------------------------
    assign in_region  = (IOBUS_ADDR[31:9] == BASE_AD[31:9]);
    assign offset     = IOBUS_ADDR[8:0];
    assign global_hit = in_region && (offset == GLOBAL_OFF);
    assign ch_space   = in_region && !offset[8];
    assign ch_idx     = offset[7:4];
    assign reg_off    = offset[3:0];

    // ------------------------------------------------------------------
    // GLOBAL register
    // ------------------------------------------------------------------
    assign global_wr = IOBUS_WR && global_hit;
    assign clr_all   = global_wr && IOBUS_OUT[GLB_CLR_ALL];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            freeze <= 1'b0;
        end else if (global_wr) begin
            freeze <= IOBUS_OUT[GLB_FREEZE];
        end
    end

    // ------------------------------------------------------------------
    // Channels. Indices at or above NUM_CH never match a select, which
    // makes them ignore writes and read back as zero.
    // ------------------------------------------------------------------
    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign ch_sel[c]  = ch_space && (ch_idx == 4'(c));
            assign ctrl_wr[c] = IOBUS_WR && ch_sel[c] && (reg_off == REG_CTRL);
            assign snap[c]    = IOBUS_RD && ch_sel[c] && (reg_off == REG_LO);

            perf_counter_ch #(
                .CNT_W  (CNT_W),
                .EN_RST (c == 0)
            ) u_ch (
                .clk        (CLK),
                .rst        (RESET),
                .evt        (EVENTS[c]),
                .freeze     (freeze),
                .clr_all    (clr_all),
                .ctrl_wr    (ctrl_wr[c]),
                .ctrl_wdata (IOBUS_OUT[2:0]),
                .snap       (snap[c]),
                .lo         (lo_rd[c]),
                .hi         (hi_rd[c]),
                .ctrl       (ctrl_rd[c])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        RD_DATA = '0;
        if (global_hit) begin
            RD_DATA[GLB_FREEZE] = freeze;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel[c]) begin
                case (reg_off)
                    REG_LO:   RD_DATA = lo_rd[c];
                    REG_HI:   RD_DATA = hi_rd[c];
                    REG_CTRL: RD_DATA = ctrl_rd[c];
                    default:  RD_DATA = '0;
                endcase
            end
        end
    end

    // Write-data bits with no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^IOBUS_OUT[31:3];

endmodule : otter_perf_counters
`default_nettype wire
